// File: rtl/cube_state_scanner_if.sv
// Bundle of the scanner's handshake, sensor and result signals.
// The slave side is the scanner; the master side drives sensors and the move sequencer.
interface cube_state_scanner_if #(
  parameter int unsigned COLOR_W      = 3,
  parameter int unsigned NUM_STICKERS = 48
);
  logic                                start;
  logic                                abort;
  logic                                move_done;
  logic                                color_valid;
  logic [COLOR_W-1:0]                  corner_color;
  logic [COLOR_W-1:0]                  edge_color;
  logic                                move_req;
  logic [5:0]                          move_index;
  logic                                busy;
  logic [(NUM_STICKERS+6)*COLOR_W-1:0] cubestate;
  logic                                cubestate_valid;
  logic                                error;
  logic [1:0]                          error_code;

  modport master (
    output start, abort, move_done, color_valid, corner_color, edge_color,
    input  move_req, move_index, busy, cubestate, cubestate_valid, error, error_code
  );

  modport slave (
    input  start, abort, move_done, color_valid, corner_color, edge_color,
    output move_req, move_index, busy, cubestate, cubestate_valid, error, error_code
  );
endinterface

// File: rtl/cube_state_scanner.sv
// Sequences sticker observations, accepts a colour once enough consecutive samples agree,
// and packs the results in place beside fixed centre colours.
module cube_state_scanner #(
  parameter int unsigned          COLOR_W       = 3,
  parameter int unsigned          NUM_COLORS    = 6,
  parameter int unsigned          NUM_STICKERS  = 48,
  parameter int unsigned          NUM_CORNER    = 24,
  parameter int unsigned          NUM_SAMPLES   = 3,
  parameter int unsigned          MAX_RETRY     = 4,
  parameter int unsigned          TIMEOUT       = 1000000,
  parameter logic [6*COLOR_W-1:0] CENTER_COLORS = 18'o543210
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  cube_state_scanner_if.slave  bus
);
  localparam int unsigned FieldsW = NUM_STICKERS * COLOR_W;
  localparam int unsigned TimerW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SCntW   = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned RetryW  = $clog2(MAX_RETRY + 2);

  // Leaving on this timer value means the timer would reach TIMEOUT-1.
  localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 2);
  localparam logic [SCntW-1:0]   SCntLast  = SCntW'(NUM_SAMPLES - 1);
  localparam logic [RetryW-1:0]  RetryMax  = RetryW'(MAX_RETRY);
  localparam logic [5:0]         LastIdx   = 6'(NUM_STICKERS - 1);
  localparam logic [5:0]         CornerLim = 6'(NUM_CORNER);
  localparam logic [COLOR_W:0]   ColorLim  = (COLOR_W + 1)'(NUM_COLORS);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitMove,
    StSample,
    StStore,
    StDone,
    StError
  } state_e;

  state_e              state_q;
  logic [5:0]          counter_q;
  logic [FieldsW-1:0]  fields_q;
  logic [COLOR_W-1:0]  ref_q;
  logic [TimerW-1:0]   timer_q;
  logic [SCntW-1:0]    scnt_q;
  logic [RetryW-1:0]   retry_q;
  logic                move_req_q;
  logic                busy_q;
  logic                valid_q;
  logic                error_q;
  logic [1:0]          code_q;

  logic [COLOR_W-1:0]  sel_color;
  logic                sel_legal;
  logic                sample_ok;

  assign sel_color = (counter_q < CornerLim) ? bus.corner_color : bus.edge_color;
  assign sel_legal = {1'b0, sel_color} < ColorLim;
  // The first sample of a run only has to be legal; later ones must also match it.
  assign sample_ok = sel_legal && ((scnt_q == '0) || (sel_color == ref_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      counter_q  <= '0;
      fields_q   <= '0;
      ref_q      <= '0;
      timer_q    <= '0;
      scnt_q     <= '0;
      retry_q    <= '0;
      move_req_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= 2'd0;
    end else begin
      move_req_q <= 1'b0;
      if (busy_q && bus.abort) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StDone, StError: begin
            if (bus.start) begin
              state_q    <= StReq;
              counter_q  <= '0;
              fields_q   <= '0;
              valid_q    <= 1'b0;
              error_q    <= 1'b0;
              code_q     <= 2'd0;
              busy_q     <= 1'b1;
              move_req_q <= 1'b1;
            end
          end
          StReq: begin
            timer_q <= '0;
            state_q <= StWaitMove;
          end
          StWaitMove: begin
            if (bus.move_done && bus.color_valid) begin
              state_q <= StSample;
              scnt_q  <= '0;
              retry_q <= '0;
            end else if (timer_q == TimerLast) begin
              state_q <= StError;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              code_q  <= 2'd1;
            end else begin
              timer_q <= timer_q + TimerW'(1);
            end
          end
          StSample: begin
            if (!bus.color_valid) begin
              scnt_q <= '0;
            end else if (sample_ok) begin
              if (scnt_q == '0) begin
                ref_q <= sel_color;
              end
              if (scnt_q == SCntLast) begin
                state_q <= StStore;
              end else begin
                scnt_q <= scnt_q + SCntW'(1);
              end
            end else begin
              scnt_q <= '0;
              if (retry_q == RetryMax) begin
                state_q <= StError;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
                code_q  <= 2'd2;
              end else begin
                retry_q <= retry_q + RetryW'(1);
              end
            end
          end
          StStore: begin
            for (int k = 0; k < NUM_STICKERS; k++) begin
              if (counter_q == 6'(k)) begin
                fields_q[k*COLOR_W +: COLOR_W] <= ref_q;
              end
            end
            if (counter_q == LastIdx) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              counter_q  <= counter_q + 6'd1;
              state_q    <= StReq;
              move_req_q <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.move_req        = move_req_q;
  assign bus.move_index      = counter_q;
  assign bus.busy            = busy_q;
  assign bus.cubestate       = {CENTER_COLORS, fields_q};
  assign bus.cubestate_valid = valid_q;
  assign bus.error           = error_q;
  assign bus.error_code      = code_q;
endmodule

// File: tb/tb_cube_state_scanner.sv
// Randomised scenario bench for cube_state_scanner against a sample-stream acceptance model.
module tb_cube_state_scanner;
  localparam int CW    = 3;
  localparam int NS    = 48;
  localparam int NC    = 24;
  localparam int NSAMP = 3;
  localparam int MAXR  = 4;
  localparam int NCOL  = 6;
  localparam int TO    = 16;
  localparam int VW    = (NS + 6) * CW;

  typedef logic [3:0] plan_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cube_state_scanner_if #(.COLOR_W(CW), .NUM_STICKERS(NS)) bus ();

  cube_state_scanner #(
    .COLOR_W     (CW),
    .NUM_COLORS  (NCOL),
    .NUM_STICKERS(NS),
    .NUM_CORNER  (NC),
    .NUM_SAMPLES (NSAMP),
    .MAX_RETRY   (MAXR),
    .TIMEOUT     (TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  int    exp_field[NS];
  int    override_k = -1;
  plan_t override_plan;

  function automatic logic [VW-1:0] expected_state();
    logic [VW-1:0] v;
    v = VW'(18'o543210) << (NS * CW);
    for (int k = 0; k < NS; k++) v = v | (VW'(exp_field[k]) << (k * CW));
    return v;
  endfunction

  function automatic void clear_fields();
    for (int k = 0; k < NS; k++) exp_field[k] = 0;
  endfunction

  // Walks a stream of {valid, colour} samples: a run of NSAMP equal legal samples accepts,
  // a disagreement or illegal code costs a retry and restarts the run, invalid resets the run.
  function automatic void judge(input plan_t s, output int used, output int colour,
                                output bit err);
    int run_len;
    int run_col;
    int misses;
    int c;
    used = -1; colour = 0; err = 1'b0;
    run_len = 0; run_col = 0; misses = 0;
    for (int i = 0; i < s.size(); i++) begin
      c = int'(s[i][2:0]);
      if (!s[i][3]) begin
        run_len = 0;
      end else if (c < NCOL && (run_len == 0 || c == run_col)) begin
        run_col = c;
        run_len++;
        if (run_len == NSAMP) begin
          used = i + 1; colour = c;
          return;
        end
      end else begin
        run_len = 0;
        misses++;
        if (misses > MAXR) begin
          used = i + 1; err = 1'b1;
          return;
        end
      end
    end
  endfunction

  task automatic make_plan(output plan_t p);
    int used, colour, good, len;
    bit err;
    do begin
      p = {};
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) p.push_back({($urandom_range(0, 3) != 0), 3'($urandom)});
      good = $urandom_range(0, NCOL - 1);
      for (int i = 0; i <= NSAMP; i++) p.push_back({1'b1, 3'(good)});
      judge(p, used, colour, err);
    end while (err || used < 0);
  endtask

  task automatic idle_inputs();
    bus.move_done    = 1'b0;
    bus.color_valid  = 1'b0;
    bus.corner_color = 3'($urandom);
    bus.edge_color   = 3'($urandom);
  endtask

  task automatic drive_sample(input int k, input logic [3:0] smp);
    bus.move_done   = 1'($urandom);
    bus.color_valid = smp[3];
    if (k < NC) begin
      bus.corner_color = smp[2:0];
      bus.edge_color   = 3'($urandom);
    end else begin
      bus.edge_color   = smp[2:0];
      bus.corner_color = 3'($urandom);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at the negedge where sticker k's move_req is visible; leaves one negedge after the
  // last sample the model says the scanner consumes.
  task automatic drive_sticker(input int k, input plan_t plan, output bit err);
    int used, colour, d;
    bit md;
    judge(plan, used, colour, err);
    d = $urandom_range(0, 6);
    for (int i = 0; i <= d; i++) begin
      md = 1'($urandom);
      bus.move_done    = md;
      bus.color_valid  = md ? 1'b0 : 1'($urandom);
      bus.corner_color = 3'($urandom);
      bus.edge_color   = 3'($urandom);
      @(negedge clk);
    end
    bus.move_done   = 1'b1;
    bus.color_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < used; i++) begin
      drive_sample(k, plan[i]);
      @(negedge clk);
    end
    idle_inputs();
    if (!err) exp_field[k] = colour;
  endtask

  task automatic scan_stickers(input int first, input int last, output bit err);
    plan_t plan;
    err = 1'b0;
    for (int k = first; k <= last; k++) begin
      checks++;
      if (bus.move_req !== 1'b1 || bus.move_index !== 6'(k)) begin
        failures++;
        $display("FAIL req_sticker%0d: move_req=%b move_index=%0d, required 1 and %0d",
                 k, bus.move_req, bus.move_index, k);
        err = 1'b1;
        return;
      end
      if (k == override_k) plan = override_plan;
      else make_plan(plan);
      drive_sticker(k, plan, err);
      if (err) return;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clear_fields();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.move_req, bus.move_index, bus.busy, bus.cubestate_valid, bus.error,
         bus.error_code} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b idx=%0d busy=%b valid=%b err=%b code=%0d, required 0",
               bus.move_req, bus.move_index, bus.busy, bus.cubestate_valid, bus.error,
               bus.error_code);
    end
    checks++;
    if (bus.cubestate !== expected_state()) begin
      failures++;
      $display("FAIL reset_cubestate: got %h, required %h", bus.cubestate, expected_state());
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.move_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: busy=%b move_req=%b, required 0 0", bus.busy, bus.move_req);
    end
  endtask

  task automatic test_clean_scan();
    int pulses, first, done;
    bus.move_done = 1'b1; bus.color_valid = 1'b1;
    bus.corner_color = 3'd1; bus.edge_color = 3'd4;
    clear_fields();
    for (int k = 0; k < NS; k++) exp_field[k] = (k < NC) ? 1 : 4;
    pulse_start();
    pulses = 0; first = -1; done = -1;
    for (int cyc = 0; cyc < 400 && done < 0; cyc++) begin
      if (bus.move_req === 1'b1) begin
        checks++;
        if (bus.move_index !== 6'(pulses)) begin
          failures++;
          $display("FAIL clean_index: move_index=%0d, required %0d", bus.move_index, pulses);
        end
        if (first < 0) first = cyc;
        pulses++;
      end
      if (bus.cubestate_valid === 1'b1) done = cyc;
      else @(negedge clk);
    end
    checks++;
    if (pulses != NS) begin
      failures++;
      $display("FAIL clean_pulses: got %0d move_req pulses, required %0d", pulses, NS);
    end
    checks++;
    if (done < 0 || first < 0 || done - first != 288) begin
      failures++;
      $display("FAIL clean_latency: first=%0d done=%0d, required done-first=288", first, done);
    end
    checks++;
    if (bus.cubestate !== expected_state() || bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      failures++;
      $display("FAIL clean_result: state=%h busy=%b err=%b, required %h 0 0",
               bus.cubestate, bus.busy, bus.error, expected_state());
    end
    idle_inputs();
  endtask

  task automatic test_random_scan();
    bit err;
    clear_fields();
    override_k = 5;
    override_plan = {4'b1010, 4'b1011, 4'b1010, 4'b1010, 4'b1010};
    pulse_start();
    checks++;
    if (bus.cubestate_valid !== 1'b0 || bus.cubestate !== expected_state()) begin
      failures++;
      $display("FAIL restart_clear: valid=%b state=%h, required 0 %h",
               bus.cubestate_valid, bus.cubestate, expected_state());
    end
    scan_stickers(0, NS - 1, err);
    checks++;
    if (bus.cubestate_valid !== 1'b1 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL random_done: valid=%b err=%b busy=%b, required 1 0 0",
               bus.cubestate_valid, bus.error, bus.busy);
    end
    checks++;
    if (bus.cubestate !== expected_state()) begin
      failures++;
      $display("FAIL random_state: got %h, required %h", bus.cubestate, expected_state());
    end
    checks++;
    if (((bus.cubestate >> (5 * CW)) & VW'(7)) !== VW'(2)) begin
      failures++;
      $display("FAIL disagree_field5: got %0d, required 2", (bus.cubestate >> (5 * CW)) & 7);
    end
  endtask

  task automatic test_retry_exhaust();
    bit err;
    clear_fields();
    override_k = 30;
    override_plan = {};
    for (int i = 0; i < 6; i++) begin
      override_plan.push_back(4'b1001);
      override_plan.push_back(4'b1111);
    end
    pulse_start();
    scan_stickers(0, 30, err);
    checks++;
    if (bus.error !== 1'b1 || bus.error_code !== 2'd2 || bus.move_index !== 6'd30) begin
      failures++;
      $display("FAIL retry_error: err=%b code=%0d idx=%0d, required 1 2 30",
               bus.error, bus.error_code, bus.move_index);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.cubestate_valid !== 1'b0 || bus.cubestate !== expected_state())
    begin
      failures++;
      $display("FAIL retry_state: busy=%b valid=%b state=%h, required 0 0 %h",
               bus.busy, bus.cubestate_valid, bus.cubestate, expected_state());
    end
    override_k = -1;
  endtask

  task automatic test_back_to_back();
    bit err;
    int reqs;
    clear_fields();
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.move_req !== 1'b1 || bus.move_index !== 6'd0 || bus.error !== 1'b0 ||
        bus.error_code !== 2'd0 || bus.busy !== 1'b1 || bus.cubestate !== expected_state()) begin
      failures++;
      $display("FAIL start_abort_error: req=%b idx=%0d err=%b code=%0d busy=%b, required 1 0 0 0 1",
               bus.move_req, bus.move_index, bus.error, bus.error_code, bus.busy);
    end
    scan_stickers(0, 9, err);
    // Sticker 10: move into SAMPLE, take one sample, then abort.
    idle_inputs();
    @(negedge clk);
    bus.move_done = 1'b1; bus.color_valid = 1'b1;
    @(negedge clk);
    drive_sample(10, 4'b1011);
    @(negedge clk);
    drive_sample(10, 4'b1011);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.move_req !== 1'b0 || bus.cubestate_valid !== 1'b0 ||
        bus.error !== 1'b0 || bus.cubestate !== expected_state()) begin
      failures++;
      $display("FAIL abort_idle: busy=%b req=%b valid=%b err=%b state=%h, required 0 0 0 0 %h",
               bus.busy, bus.move_req, bus.cubestate_valid, bus.error, bus.cubestate,
               expected_state());
    end
    bus.move_done = 1'b1; bus.color_valid = 1'b1;
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.move_req === 1'b1) reqs++;
    end
    checks++;
    if (reqs != 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d move_req pulses after abort, required 0", reqs);
    end
    clear_fields();
    pulse_start();
    checks++;
    if (bus.move_req !== 1'b1 || bus.move_index !== 6'd0 || bus.cubestate !== expected_state())
    begin
      failures++;
      $display("FAIL abort_rescan: req=%b idx=%0d state=%h, required 1 0 %h",
               bus.move_req, bus.move_index, bus.cubestate, expected_state());
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    idle_inputs();
  endtask

  task automatic test_timeout();
    int cyc_err;
    bus.move_done = 1'b0; bus.color_valid = 1'b1;
    pulse_start();
    cyc_err = -1;
    for (int cyc = 0; cyc < 100 && cyc_err < 0; cyc++) begin
      if (bus.error === 1'b1) cyc_err = cyc;
      else @(negedge clk);
    end
    checks++;
    if (cyc_err != TO) begin
      failures++;
      $display("FAIL timeout_latency: error after %0d cycles, required %0d", cyc_err, TO);
    end
    checks++;
    if (bus.error_code !== 2'd1 || bus.busy !== 1'b0 || bus.move_index !== 6'd0 ||
        bus.move_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state: code=%0d busy=%b idx=%0d req=%b, required 1 0 0 0",
               bus.error_code, bus.busy, bus.move_index, bus.move_req);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit err;
    clear_fields();
    pulse_start();
    scan_stickers(0, 3, err);
    bus.move_done = 1'b1; bus.color_valid = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    clear_fields();
    checks++;
    if ({bus.move_req, bus.move_index, bus.busy, bus.cubestate_valid, bus.error,
         bus.error_code} !== 12'd0 || bus.cubestate !== expected_state()) begin
      failures++;
      $display("FAIL reset_mid: req=%b idx=%0d busy=%b state=%h, required 0 0 0 %h",
               bus.move_req, bus.move_index, bus.busy, bus.cubestate, expected_state());
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.move_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b req=%b, required 0 0", bus.busy, bus.move_req);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    idle_inputs();
    test_reset();
    test_clean_scan();
    test_random_scan();
    test_retry_exhaust();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
